// File: rtl/argmax_window_p.sv
// Block-wise argmax/argmin over N=2**IDX_W samples after a warm-up discard.
// Reports the winning position and value through a valid/ready output with a sticky overrun flag.
module argmax_window_p #(
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 8,
    parameter int WARMUP     = 272,
    parameter int TIE_LATEST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     mode_min,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_idx,
    output logic signed [DATA_W-1:0] out_val,
    output logic                     out_overrun,
    output logic                     warm_done
);

    localparam logic [IDX_W-1:0] POS_LAST  = '1;
    localparam logic [15:0]      WARM_LAST = 16'(WARMUP - 1);
    localparam logic             WARM_INIT = (WARMUP == 0);

    logic [15:0]              warm_cnt_p0;
    logic [IDX_W-1:0]         pos_p0;
    logic signed [DATA_W-1:0] best_val_p0;
    logic [IDX_W-1:0]         best_idx_p0;
    logic                     mode_p0;

    logic                     take;
    logic                     res_vld;
    logic signed [DATA_W-1:0] win_val;
    logic [IDX_W-1:0]         win_idx;

    function automatic logic replaces(input logic signed [DATA_W-1:0] cand,
                                      input logic signed [DATA_W-1:0] best,
                                      input logic                     min_mode);
        if (cand == best)
            return (TIE_LATEST != 0);
        return min_mode ? (cand < best) : (cand > best);
    endfunction

    // Stage 0: fold the incoming sample into the running best of this window
    always_comb begin
        take    = in_valid && warm_done;
        win_val = best_val_p0;
        win_idx = best_idx_p0;
        if (pos_p0 == '0) begin
            win_val = in_data;
            win_idx = '0;
        end else if (replaces(in_data, best_val_p0, mode_p0)) begin
            win_val = in_data;
            win_idx = pos_p0;
        end
        res_vld = take && (pos_p0 == POS_LAST);
    end

    always_ff @(posedge clk) begin
        if (take) begin
            best_val_p0 <= win_val;
            best_idx_p0 <= win_idx;
            if (pos_p0 == '0)
                mode_p0 <= mode_min;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt_p0 <= '0;
            warm_done   <= WARM_INIT;
            pos_p0      <= '0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_val     <= '0;
            out_overrun <= 1'b0;
        end else if (clear) begin
            warm_cnt_p0 <= '0;
            warm_done   <= WARM_INIT;
            pos_p0      <= '0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_val     <= '0;
            out_overrun <= 1'b0;
        end else begin
            if (in_valid && !warm_done) begin
                warm_cnt_p0 <= warm_cnt_p0 + 16'd1;
                if (warm_cnt_p0 == WARM_LAST)
                    warm_done <= 1'b1;
            end
            if (take)
                pos_p0 <= pos_p0 + 1'b1;

            // Stage 1: output register; a free slot or a simultaneous transfer accepts the result
            if (res_vld && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_idx   <= win_idx;
                out_val   <= win_val;
            end else if (res_vld) begin
                out_overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
